// File: rtl/sync_fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// sync_fifo_arb_pkg
// Shared types and helpers for the Sync_FIFO write-port arbiter.
//   arb_state_t : arbiter FSM states (IDLE = arbitrate, BURST = grant held)
//   rr_next     : round-robin search over a request mask, starting just after
//                 the previous grantee and wrapping at the requester count
// ----------------------------------------------------------------------------
package sync_fifo_arb_pkg;

  // Widest requester vector the helper accepts; callers zero-extend into it.
  localparam int RR_MAX_REQ = 32;
  localparam int RR_IDX_W   = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  // Returns the first set bit of mask at or after (last+1) mod num, with wrap.
  // If the mask is empty the previous index is returned unchanged; callers
  // qualify the result with their own "any request" flag.
  function automatic int unsigned rr_next(input logic [RR_MAX_REQ-1:0] mask,
                                          input int unsigned last,
                                          input int unsigned num);
    int unsigned res;
    int unsigned pos;
    logic        hit;
    res = last;
    hit = 1'b0;
    for (int unsigned k = 32'd1; k <= 32'(RR_MAX_REQ); k++) begin
      if (k <= num) begin
        pos = (last + k) % num;
        if (!hit && mask[pos[RR_IDX_W-1:0]]) begin
          res = pos;
          hit = 1'b1;
        end else begin
          hit = hit;
        end
      end else begin
        hit = hit;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker.
// Ports:
//   req_valid [NUM_REQ-1:0] in  : per-requester request flags
//   last_id   [IDW-1:0]     in  : index granted most recently
//   found                   out : at least one request is pending
//   idx       [IDW-1:0]     out : first requester after last_id (with wrap)
// ----------------------------------------------------------------------------
module rr_pick
  import sync_fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     last_id,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  logic [RR_MAX_REQ-1:0] mask_s;

  // Widen the request vector and run the shared round-robin search.
  always_comb begin
    mask_s = RR_MAX_REQ'(req_valid);
    found  = |req_valid;
    idx    = IDW'(rr_next(mask_s, 32'(last_id), 32'(NUM_REQ)));
  end

endmodule

// File: rtl/sync_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// sync_fifo_wr_arbiter
// Shares one Sync_FIFO write port among NUM_REQ producers. Producers are
// granted round-robin; a grant lasts up to MAX_BURST accepted words, ends
// early when the grantee drops valid, and is simply held while the FIFO is
// full. A write happens only on a valid&ready handshake with the FIFO not full.
// Ports:
//   clk                         in  : clock, rising edge
//   reset                       in  : asynchronous, active-low reset
//   req_valid  [NUM_REQ-1:0]       in  : word available per requester
//   req_data   [NUM_REQ*Width-1:0] in  : requester i at [i*Width +: Width]
//   req_ready  [NUM_REQ-1:0]       out : accept strobe, one-hot or zero
//   fifo_full                      in  : FIFO Full flag
//   fifo_wr_en                     out : FIFO write enable
//   fifo_data_in [Width-1:0]       out : FIFO write data (0 outside BURST)
//   grant_active                   out : high while a grant is held
//   grant_id   [IDW-1:0]           out : current grantee, or last one in IDLE
// ----------------------------------------------------------------------------
module sync_fifo_wr_arbiter
  import sync_fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int Width     = 8,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*Width-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_full,
  output logic                     fifo_wr_en,
  output logic [Width-1:0]         fifo_data_in,
  output logic                     grant_active,
  output logic [IDW-1:0]           grant_id
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t       state_r;
  arb_state_t       state_nxt_s;
  logic [IDW-1:0]   gnt_id_r;
  logic [IDW-1:0]   last_id_r;
  logic [CW-1:0]    burst_cnt_r;
  logic             pick_found_s;
  logic [IDW-1:0]   pick_idx_s;
  logic             xfer_s;
  logic             burst_last_s;
  logic [Width-1:0] word_s [NUM_REQ];

  // Unpack the flat data bus so the grantee's word can be selected by index.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_word
    assign word_s[gi] = req_data[gi*Width +: Width];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_pick (
    .req_valid (req_valid),
    .last_id   (last_id_r),
    .found     (pick_found_s),
    .idx       (pick_idx_s)
  );

  // A word moves only when the grantee offers one and the FIFO has room.
  always_comb begin
    xfer_s       = 1'b0;
    burst_last_s = (burst_cnt_r == CW'(MAX_BURST - 1));
    if (state_r == BURST) begin
      xfer_s = req_valid[gnt_id_r] & ~fifo_full;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a dropped valid releases the grant even while full.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (!req_valid[gnt_id_r]) begin
          state_nxt_s = IDLE;
        end else if (xfer_s && burst_last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant bookkeeping: latch the pick, count words, remember the last grantee.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt_id_r    <= IDW'(NUM_REQ - 1);
      last_id_r   <= IDW'(NUM_REQ - 1);
      burst_cnt_r <= '0;
    end else begin
      if (state_r == IDLE && pick_found_s) begin
        gnt_id_r <= pick_idx_s;
      end
      if (state_r == BURST && state_nxt_s == IDLE) begin
        last_id_r   <= gnt_id_r;
        burst_cnt_r <= '0;
      end else if (xfer_s) begin
        burst_cnt_r <= burst_cnt_r + CW'(1);
      end
    end
  end

  // Outputs: handshake and FIFO write are combinational in the transfer cycle.
  always_comb begin
    fifo_wr_en   = xfer_s;
    req_ready    = '0;
    fifo_data_in = '0;
    grant_active = 1'b0;
    grant_id     = last_id_r;
    if (xfer_s) begin
      req_ready[gnt_id_r] = 1'b1;
    end else begin
      req_ready = '0;
    end
    if (state_r == BURST) begin
      grant_active = 1'b1;
      grant_id     = gnt_id_r;
      fifo_data_in = word_s[gnt_id_r];
    end else begin
      grant_active = 1'b0;
      grant_id     = last_id_r;
      fifo_data_in = '0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sync_fifo_wr_arbiter
// Directed checks of the round-robin FIFO write arbiter followed by a short
// randomized run against a depth-10 FIFO occupancy model. Inputs change on
// the falling edge; outputs are sampled 1 ns later.
// ----------------------------------------------------------------------------
module tb_sync_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int W     = 8;
  localparam int DEPTH = 10;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [W-1:0]    fifo_data_in;
  logic            grant_active;
  logic [1:0]      grant_id;

  int n_checks;
  int n_errors;

  sync_fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .Width     (W),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_active (grant_active),
    .grant_id     (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic act, input logic [1:0] id,
                            input logic wr, input logic [3:0] rdy, input logic [7:0] data);
    chk({tag, ".active"}, 32'(grant_active), 32'(act));
    chk({tag, ".id"},     32'(grant_id),     32'(id));
    chk({tag, ".wr_en"},  32'(fifo_wr_en),   32'(wr));
    chk({tag, ".ready"},  32'(req_ready),    32'(rdy));
    chk({tag, ".data"},   32'(fifo_data_in), 32'(data));
  endtask

  task automatic set_word(input int i, input logic [7:0] v);
    req_data[i*W +: W] = v;
  endtask

  // Randomized-phase state
  int         fifo_cnt;
  int         seq [NR];
  logic [3:0] rdy_prev;
  int         gid;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;

    // ---------------- Reset state ----------------
    @(negedge clk);
    @(negedge clk);
    req_valid = 4'b0100;
    set_word(2, 8'hA0);
    #1 expect_out("reset", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);

    // ---------------- Test 1: lone requester 2, six words ----------------
    @(negedge clk);
    reset = 1'b1;
    #1 expect_out("t1_idle0", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      set_word(2, 8'hA0 + 8'(k));
      #1 expect_out("t1_burst0", 1'b1, 2'd2, 1'b1, 4'b0100, 8'hA0 + 8'(k));
    end
    @(negedge clk);
    set_word(2, 8'hA4);
    #1 expect_out("t1_idle1", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_word(2, 8'hA4 + 8'(k));
      #1 expect_out("t1_burst1", 1'b1, 2'd2, 1'b1, 4'b0100, 8'hA4 + 8'(k));
    end
    @(negedge clk);
    req_valid = 4'b0000;
    #1 expect_out("t1_drop", 1'b1, 2'd2, 1'b0, 4'b0000, 8'hA5);
    @(negedge clk);
    #1 expect_out("t1_idle2", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);

    // ---------------- Test 2: all valid, order 0,1,2,3,0 ----------------
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int g = 0; g < 5; g++) begin
      int gi;
      int prev;
      gi   = g % 4;
      prev = (g == 0) ? 3 : (g - 1) % 4;
      @(negedge clk);
      req_valid = 4'b1111;
      for (int i = 0; i < NR; i++) set_word(i, {4'(i), 4'd0});
      #1 expect_out("t2_idle", 1'b0, 2'(prev), 1'b0, 4'b0000, 8'h00);
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        set_word(gi, {4'(gi), 4'(k)});
        #1 expect_out("t2_burst", 1'b1, 2'(gi), 1'b1, 4'(1 << gi), {4'(gi), 4'(k)});
      end
    end

    // ---------------- Test 3: FIFO full for 3 cycles mid-burst ----------------
    @(negedge clk);
    req_valid = 4'b0010;
    set_word(1, 8'h10);
    #1 expect_out("t3_idle", 1'b0, 2'd0, 1'b0, 4'b0000, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_word(1, {4'd1, 4'(k)});
      #1 expect_out("t3_pre", 1'b1, 2'd1, 1'b1, 4'b0010, {4'd1, 4'(k)});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      fifo_full = 1'b1;
      set_word(1, 8'h12);
      #1 expect_out("t3_stall", 1'b1, 2'd1, 1'b0, 4'b0000, 8'h12);
    end
    for (int k = 2; k < 4; k++) begin
      @(negedge clk);
      fifo_full = 1'b0;
      set_word(1, {4'd1, 4'(k)});
      #1 expect_out("t3_post", 1'b1, 2'd1, 1'b1, 4'b0010, {4'd1, 4'(k)});
    end

    // ---------------- Test 4: grantee drops valid after 2 words ----------------
    @(negedge clk);
    req_valid = 4'b1100;
    set_word(2, 8'h20);
    set_word(3, 8'h30);
    #1 expect_out("t4_idle", 1'b0, 2'd1, 1'b0, 4'b0000, 8'h00);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_word(2, {4'd2, 4'(k)});
      #1 expect_out("t4_burst", 1'b1, 2'd2, 1'b1, 4'b0100, {4'd2, 4'(k)});
    end
    @(negedge clk);
    req_valid = 4'b1000;
    set_word(2, 8'h22);
    #1 expect_out("t4_drop", 1'b1, 2'd2, 1'b0, 4'b0000, 8'h22);
    @(negedge clk);
    #1 expect_out("t4_idle2", 1'b0, 2'd2, 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    #1 expect_out("t4_regrant", 1'b1, 2'd3, 1'b1, 4'b1000, 8'h30);

    // ---------------- Test 5: asynchronous reset mid-burst ----------------
    #2 reset = 1'b0;
    #1 expect_out("t5_async", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    reset     = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < NR; i++) set_word(i, {4'(i), 4'd0});
    #1 expect_out("t5_idle", 1'b0, 2'd3, 1'b0, 4'b0000, 8'h00);
    @(negedge clk);
    #1 expect_out("t5_first", 1'b1, 2'd0, 1'b1, 4'b0001, 8'h00);

    // ---------------- Test 6: random valid/full against a FIFO model ----------------
    fifo_cnt  = 0;
    rdy_prev  = '0;
    req_valid = '0;
    for (int i = 0; i < NR; i++) seq[i] = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (fifo_cnt > 0 && $urandom_range(0, 2) == 0) fifo_cnt--;
      fifo_full = (fifo_cnt == DEPTH);
      for (int i = 0; i < NR; i++) begin
        // Hold an offered word until it is accepted.
        if (!(req_valid[i] && !rdy_prev[i])) req_valid[i] = ($urandom_range(0, 3) != 0);
        set_word(i, {2'(i), 6'(seq[i])});
      end
      #1;
      chk("t6_no_wr_when_full", 32'(fifo_wr_en & fifo_full), 32'd0);
      chk("t6_ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("t6_ready_vs_wr", 32'(|req_ready), 32'(fifo_wr_en));
      chk("t6_ready_only_valid", 32'(req_ready & ~req_valid), 32'd0);
      if (fifo_wr_en) begin
        gid = 0;
        for (int i = 0; i < NR; i++) if (req_ready[i]) gid = i;
        chk("t6_data_order", 32'(fifo_data_in), 32'({2'(gid), 6'(seq[gid])}));
        seq[gid]++;
        fifo_cnt++;
      end
      rdy_prev = req_ready;
    end
    for (int i = 0; i < NR; i++) chk("t6_served", 32'(seq[i] > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
